// File: rtl/axi_arbiter.sv
// Two-master AXI4 arbiter: IFU (read) and LSU (read/write) share one downstream port.
// One whole transaction is granted at a time; the granted master's channels are forwarded combinationally.
module axi_arbiter #(
   parameter bit          FAIR        = 1'b0,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ifu_araddr,
   input  logic [3:0]  ifu_arid,
   input  logic [7:0]  ifu_arlen,
   input  logic [2:0]  ifu_arsize,
   input  logic [1:0]  ifu_arburst,
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_rresp,
   output logic        ifu_rlast,
   output logic [3:0]  ifu_rid,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   input  logic [31:0] lsu_araddr,
   input  logic [3:0]  lsu_arid,
   input  logic [7:0]  lsu_arlen,
   input  logic [2:0]  lsu_arsize,
   input  logic [1:0]  lsu_arburst,
   input  logic        lsu_arvalid,
   output logic        lsu_arready,
   output logic [31:0] lsu_rdata,
   output logic [1:0]  lsu_rresp,
   output logic        lsu_rlast,
   output logic [3:0]  lsu_rid,
   output logic        lsu_rvalid,
   input  logic        lsu_rready,
   input  logic [31:0] lsu_awaddr,
   input  logic [3:0]  lsu_awid,
   input  logic [7:0]  lsu_awlen,
   input  logic [2:0]  lsu_awsize,
   input  logic [1:0]  lsu_awburst,
   input  logic        lsu_awvalid,
   output logic        lsu_awready,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wstrb,
   input  logic        lsu_wlast,
   input  logic        lsu_wvalid,
   output logic        lsu_wready,
   output logic [1:0]  lsu_bresp,
   output logic [3:0]  lsu_bid,
   output logic        lsu_bvalid,
   input  logic        lsu_bready,
   output logic [31:0] m_araddr,
   output logic [3:0]  m_arid,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast,
   input  logic [3:0]  m_rid,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic [31:0] m_awaddr,
   output logic [3:0]  m_awid,
   output logic [7:0]  m_awlen,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wlast,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic [3:0]  m_bid,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic        arb_timeout,
   output logic [1:0]  grant
);

   localparam int unsigned      TMR_W = 32;
   localparam logic [TMR_W-1:0] TMO   = TMR_W'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFU_RD = 2'd1,
      LSU_RD = 2'd2,
      LSU_WR = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   state_t           w_lsu_cand;
   logic             r_last_lsu;
   logic             r_ar_done;
   logic             r_aw_done;
   logic             r_w_done;
   logic             r_timeout;
   logic [TMR_W-1:0] r_timer;
   logic             w_req_i;
   logic             w_req_lr;
   logic             w_req_lw;

   assign w_req_i    = ifu_arvalid;
   assign w_req_lr   = lsu_arvalid;
   assign w_req_lw   = lsu_awvalid | lsu_wvalid;
   assign w_lsu_cand = w_req_lw ? LSU_WR : LSU_RD;
   assign grant       = r_state;
   assign arb_timeout = r_timeout;

   // Next-state selection and channel forwarding for the current owner
   always_comb begin
      w_next      = r_state;
      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = '0;
      ifu_rlast   = 1'b0;
      ifu_rid     = '0;
      ifu_rvalid  = 1'b0;
      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = '0;
      lsu_rlast   = 1'b0;
      lsu_rid     = '0;
      lsu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = '0;
      lsu_bid     = '0;
      lsu_bvalid  = 1'b0;
      m_araddr    = '0;
      m_arid      = '0;
      m_arlen     = '0;
      m_arsize    = '0;
      m_arburst   = '0;
      m_arvalid   = 1'b0;
      m_rready    = 1'b0;
      m_awaddr    = '0;
      m_awid      = '0;
      m_awlen     = '0;
      m_awsize    = '0;
      m_awburst   = '0;
      m_awvalid   = 1'b0;
      m_wdata     = '0;
      m_wstrb     = '0;
      m_wlast     = 1'b0;
      m_wvalid    = 1'b0;
      m_bready    = 1'b0;
      case (r_state)
         IDLE: begin
            if ((w_req_lw | w_req_lr) && w_req_i) begin
               // Fair mode: the master that won last time yields the tie
               if (!FAIR || !r_last_lsu) w_next = w_lsu_cand;
               else                      w_next = IFU_RD;
            end else if (w_req_lw | w_req_lr) begin
               w_next = w_lsu_cand;
            end else if (w_req_i) begin
               w_next = IFU_RD;
            end
         end
         IFU_RD: begin
            m_araddr    = ifu_araddr;
            m_arid      = ifu_arid;
            m_arlen     = ifu_arlen;
            m_arsize    = ifu_arsize;
            m_arburst   = ifu_arburst;
            m_arvalid   = ifu_arvalid & ~r_ar_done;
            ifu_arready = m_arready & ~r_ar_done;
            ifu_rdata   = m_rdata;
            ifu_rresp   = m_rresp;
            ifu_rlast   = m_rlast;
            ifu_rid     = m_rid;
            ifu_rvalid  = m_rvalid;
            m_rready    = ifu_rready;
            if (m_rvalid && ifu_rready && m_rlast) w_next = IDLE;
         end
         LSU_RD: begin
            m_araddr    = lsu_araddr;
            m_arid      = lsu_arid;
            m_arlen     = lsu_arlen;
            m_arsize    = lsu_arsize;
            m_arburst   = lsu_arburst;
            m_arvalid   = lsu_arvalid & ~r_ar_done;
            lsu_arready = m_arready & ~r_ar_done;
            lsu_rdata   = m_rdata;
            lsu_rresp   = m_rresp;
            lsu_rlast   = m_rlast;
            lsu_rid     = m_rid;
            lsu_rvalid  = m_rvalid;
            m_rready    = lsu_rready;
            if (m_rvalid && lsu_rready && m_rlast) w_next = IDLE;
         end
         LSU_WR: begin
            m_awaddr    = lsu_awaddr;
            m_awid      = lsu_awid;
            m_awlen     = lsu_awlen;
            m_awsize    = lsu_awsize;
            m_awburst   = lsu_awburst;
            m_awvalid   = lsu_awvalid & ~r_aw_done;
            lsu_awready = m_awready & ~r_aw_done;
            m_wdata     = lsu_wdata;
            m_wstrb     = lsu_wstrb;
            m_wlast     = lsu_wlast;
            m_wvalid    = lsu_wvalid & ~r_w_done;
            lsu_wready  = m_wready & ~r_w_done;
            lsu_bresp   = m_bresp;
            lsu_bid     = m_bid;
            lsu_bvalid  = m_bvalid;
            m_bready    = lsu_bready;
            if (m_bvalid && lsu_bready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Per-transaction address/data handshake tracking and tie-break history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_lsu <= 1'b0;
         r_ar_done  <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
      end else begin
         if (r_state == IDLE && w_next != IDLE) r_last_lsu <= (w_next != IFU_RD);
         if (r_state == IDLE) begin
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (m_arvalid && m_arready)            r_ar_done <= 1'b1;
            if (m_awvalid && m_awready)            r_aw_done <= 1'b1;
            if (m_wvalid && m_wready && m_wlast)   r_w_done  <= 1'b1;
         end
      end
   end

   // Open-transaction timer; the flag is sticky and never aborts the transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer   <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == IDLE)  r_timer <= '0;
         else if (r_timer != TMO) r_timer <= r_timer + TMR_W'(1);
         if (TIMEOUT_CYC != 0 && r_state != IDLE && (r_timer + TMR_W'(1)) == TMO)
            r_timeout <= 1'b1;
      end
   end

endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Shares one AXI4 master port to memory/peripherals between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Sits between the IFU/LSU AXI master ports and the single downstream slave (SRAM/crossbar).
- Grants one whole transaction at a time, from address handshake through final response, using a registered FSM.
- Forwards the granted master's channels combinationally.

Parameters:
- FAIR, 0: tie policy. 0 = LSU always wins. 1 = alternate; the master granted last loses a tie.
- TIMEOUT_CYC, 1024: cycles a granted transaction may stay open before arb_timeout sets. 0 disables the check.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ifu_ar{addr,id,len,size,burst,valid} / ifu_arready  in / out  32,4,8,3,2,1 / 1  IFU read-address channel
- ifu_r{data,resp,last,id,valid} / ifu_rready  out / in  32,2,1,4,1 / 1  IFU read-data channel
- lsu_ar* / lsu_arready  in / out  same widths as ifu_ar*  LSU read-address channel
- lsu_r* / lsu_rready  out / in  same widths as ifu_r*  LSU read-data channel
- lsu_aw{addr,id,len,size,burst,valid} / lsu_awready  in / out  32,4,8,3,2,1 / 1  LSU write-address channel
- lsu_w{data,strb,last,valid} / lsu_wready  in / out  32,4,1,1 / 1  LSU write-data channel
- lsu_b{resp,id,valid} / lsu_bready  out / in  2,4,1 / 1  LSU write-response channel
- m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror  same widths  downstream master port; directions opposite to the slave-side ports above
- arb_timeout  out  1  sticky flag; set when a transaction exceeds TIMEOUT_CYC
- grant  out  2  current owner: 0 none, 1 IFU read, 2 LSU read, 3 LSU write

Behaviour:
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. Encoding is the grant output.
- Reset (async, any time, including mid-burst):
  - state IDLE, grant 0, arb_timeout 0, timer 0, last-winner = IFU.
  - All valid/ready outputs on both sides 0 immediately. Payload outputs 0.
  - An in-flight downstream transaction is abandoned; the downstream slave shares the reset.
- Request terms:
  - req_i = ifu_arvalid
  - req_lr = lsu_arvalid
  - req_lw = lsu_awvalid | lsu_wvalid
- IDLE grant selection, registered; forwarding starts the cycle after the request is seen:
  - LSU candidate: LSU_WR if req_lw, else LSU_RD if req_lr. Write beats read.
  - If an LSU candidate and req_i are both present:
    - FAIR=0: the LSU candidate wins.
    - FAIR=1: the master other than last-winner wins.
  - If only one request is present, it wins. No request: stay IDLE.
- In IDLE, every ready/valid toward masters and downstream is 0.
- IFU_RD:
  - m_ar* = ifu_ar*. ifu_arready = m_arready. ifu_r* = m_r*. m_rready = ifu_rready.
  - LSU ready/valid outputs are held 0.
  - m_ar* valid is masked to 0 after the AR handshake, so a master re-asserting arvalid early is never re-issued.
- LSU_RD: same forwarding as IFU_RD, using the LSU read channels.
- LSU_WR:
  - m_aw*, m_w* driven from LSU. m_b* returned to LSU. Ready signals pass through.
  - AW and W are each masked after their own handshake; their order is free.
  - m_ar*valid and m_rready are 0.
- Completion:
  - Read states return to IDLE on the edge where rvalid & rready & rlast.
  - LSU_WR returns to IDLE on bvalid & bready.
  - After completion, IDLE lasts at least one cycle; back-to-back transactions cost one bubble cycle.
  - last-winner updates on entry to a granted state.
- Pass-through rules:
  - rresp/bresp, including SLVERR/DECERR, are passed through unmodified. Errors do not change FSM flow.
  - IDs are passed through. The arbiter does not remap them.
  - A burst (len>0) holds the grant for all beats. Only the last beat ends it.
- Timer:
  - Clears on entry to a granted state and counts each cycle while granted.
  - When it reaches TIMEOUT_CYC, arb_timeout sets and holds until rst.
  - The FSM keeps waiting; the flag does not abort the transaction.

Test Plan:
- Lone IFU fetch: ifu_arvalid=1, araddr=0x80000000; slave gives arready at T+2 and rdata=0x00000413, rlast=1 at T+5. Required: grant=1 from T+1; ifu_rdata=0x00000413 with ifu_rvalid at T+5; grant=0 at T+6.
- Simultaneous requests, FAIR=0: ifu_arvalid and lsu_arvalid both rise at T. Required: grant=2 first; IFU served after the LSU rlast plus 1 IDLE cycle. With FAIR=1 and last-winner=LSU, IFU is served first.
- LSU write, W before AW: lsu_wvalid at T+1, lsu_awvalid at T+3, wdata=0xDEADBEEF, strb=0xF; slave bresp=OKAY. Required: m_wdata=0xDEADBEEF; each valid is dropped after its own handshake; grant=0 on the cycle after bvalid & bready.
- Burst read, len=3, with ifu_arvalid pending: grant stays 2 for all 4 beats; IFU is granted only after the 4th beat (rlast).
- Reset mid-transaction: assert rst asynchronously during an LSU_RD data beat. Required: all valid/ready outputs 0 within the same cycle and grant=0; after release, a new IFU request is granted normally.
- Timeout, TIMEOUT_CYC=8: slave never asserts rvalid. Required: arb_timeout=1 exactly 8 cycles after grant; grant is still 2; the flag stays set after the slave finally responds.
